// File: rtl/iobuf_pair_loopback_tester.sv
// Self-test for jumpered tristate pad pairs: each pad drives 0 and 1 in turn while its partner
// listens through a 2-flop synchroniser; per-pair miscompares and the first failing step are latched.
//
//   state | meaning
//   IDLE  | all pads released, waiting for start
//   TURN  | one-cycle bus turnaround, all pads released
//   DRIVE | step driver active, receiver sampled on the last settle cycle
//   DONE  | all pads released, results held until next start
module iobuf_pair_loopback_tester #(
  parameter int NUM_PAIRS     = 2,
  parameter int SETTLE_CYCLES = 8,
  localparam int STEP_W = ($clog2(4*NUM_PAIRS) > 1) ? $clog2(4*NUM_PAIRS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  inout  wire  [2*NUM_PAIRS-1:0] io,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_PAIRS-1:0] fail_mask,
  output logic [STEP_W-1:0]    first_fail
);

  localparam int IO_W      = 2*NUM_PAIRS;
  localparam int NUM_STEPS = 4*NUM_PAIRS;
  localparam int CNT_W     = ($clog2(SETTLE_CYCLES+1) > 1) ? $clog2(SETTLE_CYCLES+1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES-1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS-1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PAIRS-1:0]  fail_mask_q, fail_mask_d;
  logic [STEP_W-1:0]     first_fail_q, first_fail_d;
  logic                  done_q, done_d;
  logic [IO_W-1:0]       oe_q, oe_d;
  logic [IO_W-1:0]       o_q, o_d;
  logic [IO_W-1:0]       sync1_q, sync2_q;

  int                    cur_drv, cur_rx, cur_pair, nxt_drv;
  logic                  rx_bit;

  for (genvar gi = 0; gi < IO_W; gi++) begin : g_pad
    assign io[gi] = oe_q[gi] ? o_q[gi] : 1'bz;
  end

  // Pad enables are registered from the next state so reset releases them glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      cnt_q        <= '0;
      fail_mask_q  <= '0;
      first_fail_q <= '0;
      done_q       <= 1'b0;
      oe_q         <= '0;
      o_q          <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      fail_mask_q  <= fail_mask_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
      oe_q         <= oe_d;
      o_q          <= o_d;
      sync1_q      <= io;
      sync2_q      <= sync1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    fail_mask_d  = fail_mask_q;
    first_fail_d = first_fail_q;
    done_d       = done_q;

    cur_pair = int'(step_q >> 2);
    cur_drv  = 2*cur_pair + int'(step_q[1]);
    cur_rx   = cur_drv ^ 1;
    rx_bit   = 1'b0;
    for (int i = 0; i < IO_W; i++) begin
      if (i == cur_rx) rx_bit = sync2_q[i];
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_TURN;
          step_d       = '0;
          fail_mask_d  = '0;
          first_fail_d = '0;
          done_d       = 1'b0;
        end
      end
      ST_TURN: begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
      end
      ST_DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (rx_bit != step_q[0]) begin
            for (int k = 0; k < NUM_PAIRS; k++) begin
              if (k == cur_pair) fail_mask_d[k] = 1'b1;
            end
            if (fail_mask_q == '0) first_fail_d = step_q;
          end
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ST_TURN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    nxt_drv = 2*int'(step_d >> 2) + int'(step_d[1]);
    oe_d    = '0;
    o_d     = '0;
    for (int i = 0; i < IO_W; i++) begin
      if (state_d == ST_DRIVE && i == nxt_drv) begin
        oe_d[i] = 1'b1;
        o_d[i]  = step_d[0];
      end
    end
  end

  assign busy       = (state_q == ST_TURN) || (state_q == ST_DRIVE);
  assign done       = done_q;
  assign pass       = done_q && (fail_mask_q == '0);
  assign fail_mask  = fail_mask_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_iobuf_pair_loopback_tester.sv
// Bench for iobuf_pair_loopback_tester: models the board jumpers and weak pulls around the pads,
// runs a table of wiring scenarios and a few hand-written timing sequences.
module tb_iobuf_pair_loopback_tester;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_s;
  wire  [3:0] io;
  wire  [1:0] io_s;
  logic busy, done, pass;
  logic [1:0] fail_mask;
  logic [2:0] first_fail;
  logic busy_s, done_s, pass_s;
  logic [0:0] fail_mask_s;
  logic [1:0] first_fail_s;

  logic [1:0] jmp;
  logic [3:0] pu, pd;
  wire  [3:0] tb_en, tb_val;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iobuf_pair_loopback_tester #(.NUM_PAIRS(2), .SETTLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .io(io), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .first_fail(first_fail)
  );

  iobuf_pair_loopback_tester #(.NUM_PAIRS(1), .SETTLE_CYCLES(3)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .io(io_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .fail_mask(fail_mask_s), .first_fail(first_fail_s)
  );

  // Board model: a closed jumper copies the partner's driven value; pulls act only on released pads.
  for (genvar j = 0; j < 4; j++) begin : g_board
    assign tb_en[j]  = (jmp[j/2] && dut.oe_q[j^1]) || ((pu[j] || pd[j]) && !dut.oe_q[j]);
    assign tb_val[j] = (jmp[j/2] && dut.oe_q[j^1]) ? dut.o_q[j^1] : pu[j];
    assign io[j]     = tb_en[j] ? tb_val[j] : 1'bz;
  end
  assign io_s[1] = u_small.oe_q[0] ? u_small.o_q[0] : 1'bz;
  assign io_s[0] = u_small.oe_q[1] ? u_small.o_q[1] : 1'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive-signature monitor: at most one pad enabled, nothing driven while idle, and any change of
  // driver or driven value must pass through an all-released cycle.
  logic [7:0] prev_sig;
  logic [7:0] cur_sig;
  always @(negedge clk) begin
    cur_sig = {dut.oe_q, dut.oe_q & dut.o_q};
    if (rst) begin
      prev_sig = '0;
    end else begin
      chk("contention_monitor",
          {31'd0, ($countones(dut.oe_q) <= 1) && (busy || dut.oe_q == 4'd0) &&
                  !(prev_sig[7:4] != 4'd0 && cur_sig[7:4] != 4'd0 && cur_sig != prev_sig)},
          32'd1);
      prev_sig = cur_sig;
    end
  end

  task automatic run(input int poke_at, output int cyc, output int bcnt, output logic d0, output logic b0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d0   = done;
    b0   = busy;
    bcnt = busy ? 1 : 0;
    cyc  = 0;
    while (cyc < 1000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
      if (busy) bcnt++;
      start = (cyc == poke_at);
    end
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [1:0] jmp;
    logic [3:0] pu;
    logic [3:0] pd;
    logic [1:0] exp_mask;
    logic [2:0] exp_ff;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, bcnt;
    logic d0, b0;

    vecs[0] = '{"both_connected",   2'b11, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1};
    vecs[1] = '{"pair1_pulldowns",  2'b01, 4'b0000, 4'b1100, 2'b10, 3'd5, 1'b0};
    vecs[2] = '{"pair0_pullup_b",   2'b10, 4'b0010, 4'b0000, 2'b01, 3'd0, 1'b0};
    vecs[3] = '{"all_open_pd",      2'b00, 4'b0000, 4'b1111, 2'b11, 3'd1, 1'b0};
    vecs[4] = '{"all_open_pu",      2'b00, 4'b1111, 4'b0000, 2'b11, 3'd0, 1'b0};
    vecs[5] = '{"pair1_pd_a_pu_b",  2'b01, 4'b1000, 4'b0100, 2'b10, 3'd4, 1'b0};

    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    jmp = 2'b11; pu = '0; pd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_first_fail", first_fail, 0);
    chk("rst_oe", dut.oe_q, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      jmp = vecs[i].jmp; pu = vecs[i].pu; pd = vecs[i].pd;
      run(-1, cyc, bcnt, d0, b0);
      chk({vecs[i].name, "_done_cleared"}, d0, 0);
      chk({vecs[i].name, "_busy_first"}, b0, 1);
      chk({vecs[i].name, "_cycles"}, cyc, 72);
      chk({vecs[i].name, "_busy_cycles"}, bcnt, 72);
      chk({vecs[i].name, "_pass"}, pass, vecs[i].exp_pass);
      chk({vecs[i].name, "_fail_mask"}, fail_mask, vecs[i].exp_mask);
      chk({vecs[i].name, "_first_fail"}, first_fail, vecs[i].exp_ff);
    end

    // start pulsed mid-run is ignored
    jmp = 2'b11; pu = '0; pd = '0;
    run(20, cyc, bcnt, d0, b0);
    chk("poke_cycles", cyc, 72);
    chk("poke_pass", pass, 1);
    repeat (3) @(posedge clk);
    #1 chk("done_sticky", done, 1);

    // reset in the middle of a failing run
    jmp = 2'b10; pu = 4'b0010;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("pre_rst_fail_mask", fail_mask, 1);
    chk("pre_rst_oe_active", dut.oe_q != 4'd0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", dut.oe_q, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fail_mask", fail_mask, 0);
    @(negedge clk) rst = 1'b0;
    jmp = 2'b11; pu = '0;
    run(-1, cyc, bcnt, d0, b0);
    chk("post_rst_cycles", cyc, 72);
    chk("post_rst_pass", pass, 1);

    // single pair, minimum settle
    @(negedge clk) start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    chk("small_busy_first", busy_s, 1);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done_s) break;
    end
    chk("small_cycles", cyc, 16);
    chk("small_pass", pass_s, 1);
    chk("small_fail_mask", fail_mask_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
